// File: rtl/program_sequencer_if.sv
// Run-sequencer bus: job parameters, input/result byte streams,
// DataMem side port and processor start/ack handshake.
interface program_sequencer_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          Go;
   logic [7:0]    NumIn;
   logic [7:0]    NumOut;
   logic [AW-1:0] BaseIn;
   logic [AW-1:0] BaseOut;
   logic          InValid;
   logic [DW-1:0] InData;
   logic          InReady;
   logic          OutValid;
   logic [DW-1:0] OutData;
   logic          OutReady;
   logic          MemSel;
   logic          MemWrEn;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWrData;
   logic [DW-1:0] MemRdData;
   logic          Start;
   logic          Ack;
   logic          Busy;
   logic          Done;
   logic          TimedOut;
   logic [15:0]   RunCycles;

   // Sequencer side
   modport master (
      input  Go, NumIn, NumOut, BaseIn, BaseOut, InValid, InData, OutReady,
             MemRdData, Ack,
      output InReady, OutValid, OutData, MemSel, MemWrEn, MemAddr, MemWrData,
             Start, Busy, Done, TimedOut, RunCycles
   );

   // Environment side (host, processor, DataMem mux)
   modport slave (
      output Go, NumIn, NumOut, BaseIn, BaseOut, InValid, InData, OutReady,
             MemRdData, Ack,
      input  InReady, OutValid, OutData, MemSel, MemWrEn, MemAddr, MemWrData,
             Start, Busy, Done, TimedOut, RunCycles
   );
endinterface

// File: rtl/program_sequencer.sv
// Run sequencer: loads input bytes into DataMem, strobes Start, times the
// processor run until Ack or timeout, then drains result bytes from DataMem.
module program_sequencer #(
   parameter int          AW        = 8,
   parameter int          DW        = 8,
   parameter int unsigned TIMEOUT   = 65535,
   parameter int unsigned START_CYC = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   program_sequencer_if.master  bus
);

   localparam logic [15:0] TO_L   = 16'(TIMEOUT);
   localparam logic [15:0] SC_END = 16'(START_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    idx_q, idx_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   run_cycles_q, run_cycles_d;
   logic          timed_out_q, timed_out_d;
   logic [7:0]    num_in_q, num_in_d;
   logic [7:0]    num_out_q, num_out_d;
   logic [AW-1:0] base_in_q, base_in_d;
   logic [AW-1:0] base_out_q, base_out_d;

   // Next-state: job acceptance, beat counting, start hold, run timing
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      run_cycles_d = run_cycles_q;
      timed_out_d  = timed_out_q;
      num_in_d     = num_in_q;
      num_out_d    = num_out_q;
      base_in_d    = base_in_q;
      base_out_d   = base_out_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Go) begin
               num_in_d     = bus.NumIn;
               num_out_d    = bus.NumOut;
               base_in_d    = bus.BaseIn;
               base_out_d   = bus.BaseOut;
               timed_out_d  = 1'b0;
               run_cycles_d = '0;
               idx_d        = '0;
               cnt_d        = '0;
               state_d      = (bus.NumIn == 8'd0) ? S_START : S_LOAD;
            end
         end
         S_LOAD: begin
            if (bus.InValid) begin
               if (idx_q == num_in_q - 8'd1) begin
                  state_d = S_START;
                  cnt_d   = '0;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_START: begin
            if (cnt_q == SC_END) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RUN: begin
            // Ack takes priority over a coincident timeout
            if (bus.Ack) begin
               run_cycles_d = cnt_q + 16'd1;
               idx_d        = '0;
               state_d      = (num_out_q == 8'd0) ? S_DONE : S_DRAIN;
            end else if (cnt_q + 16'd1 == TO_L) begin
               run_cycles_d = TO_L;
               timed_out_d  = 1'b1;
               state_d      = S_DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DRAIN: begin
            if (bus.OutReady) begin
               if (idx_q == num_out_q - 8'd1) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         run_cycles_q <= '0;
         timed_out_q  <= 1'b0;
         num_in_q     <= '0;
         num_out_q    <= '0;
         base_in_q    <= '0;
         base_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         run_cycles_q <= run_cycles_d;
         timed_out_q  <= timed_out_d;
         num_in_q     <= num_in_d;
         num_out_q    <= num_out_d;
         base_in_q    <= base_in_d;
         base_out_q   <= base_out_d;
      end
   end

   // Output decode from registered state; memory port passes data through
   always_comb begin
      bus.InReady   = 1'b0;
      bus.OutValid  = 1'b0;
      bus.OutData   = '0;
      bus.MemSel    = 1'b0;
      bus.MemWrEn   = 1'b0;
      bus.MemAddr   = '0;
      bus.MemWrData = '0;
      bus.Start     = 1'b0;
      bus.Done      = 1'b0;
      bus.Busy      = (state_q != S_IDLE);
      bus.TimedOut  = timed_out_q;
      bus.RunCycles = run_cycles_q;
      unique case (state_q)
         S_LOAD: begin
            bus.MemSel    = 1'b1;
            bus.InReady   = 1'b1;
            bus.MemWrEn   = bus.InValid;
            bus.MemAddr   = base_in_q + AW'(idx_q);
            bus.MemWrData = bus.InData;
         end
         S_START: bus.Start = 1'b1;
         S_DRAIN: begin
            bus.MemSel   = 1'b1;
            bus.OutValid = 1'b1;
            bus.MemAddr  = base_out_q + AW'(idx_q);
            bus.OutData  = bus.MemRdData;
         end
         S_DONE:  bus.Done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized self-checking bench for program_sequencer: each job is predicted
// at transaction level (write list, run length, timeout flag, drained bytes).
module tb_program_sequencer;

   localparam int unsigned TO = 8;
   localparam int unsigned SC = 1;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   logic [7:0] pre_din [$];

   program_sequencer_if #(.AW(8), .DW(8)) bus ();

   program_sequencer #(
      .AW(8), .DW(8), .TIMEOUT(TO), .START_CYC(SC)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   assign bus.MemRdData = mem[bus.MemAddr];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] drives();
      return 64'({bus.InReady, bus.OutValid, bus.OutData, bus.MemSel, bus.MemWrEn,
                  bus.MemAddr, bus.MemWrData, bus.Start});
   endfunction

   function automatic logic [63:0] all_out();
      return 64'({drives(), bus.Busy, bus.Done, bus.TimedOut, bus.RunCycles});
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic rand_params();
      bus.NumIn   = 8'($urandom);
      bus.NumOut  = 8'($urandom);
      bus.BaseIn  = 8'($urandom);
      bus.BaseOut = 8'($urandom);
   endtask

   task automatic run_job(input int ni, input int no, input logic [7:0] bi,
                          input logic [7:0] bo, input int ack_at,
                          input logic [7:0] vpat, input logic [7:0] rpat,
                          input bit use_pat, input bit go_dup);
      logic [7:0] din [$];
      logic [7:0] exp_wa [$];
      logic [7:0] exp_wd [$];
      logic [7:0] got_wa [$];
      logic [7:0] got_wd [$];
      logic [7:0] exp_oa [$];
      logic [7:0] exp_od [$];
      logic [7:0] got_oa [$];
      logic [7:0] got_od [$];
      int dptr = 0, cyc = 0, lcyc = 0, dcyc = 0, run_seen = 0, start_cnt = 0;
      int first_start = -1, last_wr = -1, done_cnt = 0, busy_gap = 0, ov_cnt = 0;
      int exp_rc, exp_last, ones;
      bit fin = 1'b0, in_run, prev_stall = 1'b0, exp_to;
      logic [7:0] prev_addr = '0, prev_data = '0, d;

      // Reference: memory image after the load, then the bytes a drain returns
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      for (int i = 0; i < ni; i++) begin
         if (pre_din.size() > 0) d = pre_din.pop_front();
         else                    d = 8'($urandom);
         din.push_back(d);
         exp_wa.push_back(bi + 8'(i));
         exp_wd.push_back(d);
         ref_mem[bi + 8'(i)] = d;
      end
      exp_to = (ack_at > int'(TO));
      exp_rc = exp_to ? int'(TO) : ack_at;
      if (!exp_to) begin
         for (int i = 0; i < no; i++) begin
            exp_oa.push_back(bo + 8'(i));
            exp_od.push_back(ref_mem[bo + 8'(i)]);
         end
      end
      // With a fixed valid pattern, the last write lands on the ni-th valid cycle
      exp_last = -1;
      ones = 0;
      for (int k = 0; k < 2000 && ones < ni; k++) begin
         if (k >= 8 || vpat[k]) begin
            ones++;
            exp_last = k;
         end
      end

      bus.Go      = 1'b1;
      bus.NumIn   = 8'(ni);
      bus.NumOut  = 8'(no);
      bus.BaseIn  = bi;
      bus.BaseOut = bo;
      #1;
      check("idle_before_go", 64'(bus.Busy), 0);
      tick();
      bus.Go = 1'b0;
      rand_params();

      while (!fin && cyc < 3000) begin
         if (cyc == 0) begin
            check("go_clears_timedout", 64'(bus.TimedOut), 0);
            check("first_state", 64'((ni == 0) ? bus.Start : bus.InReady), 1);
         end
         if (!bus.Busy) busy_gap++;
         in_run = bus.Busy && !bus.MemSel && !bus.Start && !bus.Done;
         if (in_run) run_seen++;
         bus.Ack = in_run && (run_seen == ack_at);
         bus.Go  = go_dup && in_run;
         rand_params();
         if (bus.InReady) begin
            bus.InValid = use_pat ? ((lcyc < 8) ? vpat[lcyc] : 1'b1) : 1'($urandom);
            lcyc++;
         end else begin
            bus.InValid = 1'($urandom);
         end
         bus.InData = (dptr < din.size()) ? din[dptr] : 8'($urandom);
         if (bus.OutValid) begin
            bus.OutReady = use_pat ? ((dcyc < 8) ? rpat[dcyc] : 1'b1) : 1'($urandom);
            dcyc++;
         end else begin
            bus.OutReady = 1'($urandom);
         end
         #1;
         check("wren_is_beat", 64'(bus.MemWrEn), 64'(bus.InValid & bus.InReady));
         if (bus.MemSel && bus.MemWrEn) begin
            got_wa.push_back(bus.MemAddr);
            got_wd.push_back(bus.MemWrData);
            mem[bus.MemAddr] = bus.MemWrData;
            last_wr = cyc;
         end
         if (bus.InValid && bus.InReady) dptr++;
         if (bus.Start) begin
            if (start_cnt == 0) first_start = cyc;
            start_cnt++;
            check("start_memsel", 64'(bus.MemSel), 0);
         end
         if (bus.OutValid) ov_cnt++;
         if (prev_stall) begin
            check("hold_addr", 64'(bus.MemAddr), 64'(prev_addr));
            check("hold_data", 64'(bus.OutData), 64'(prev_data));
         end
         prev_stall = bus.OutValid && !bus.OutReady;
         prev_addr  = bus.MemAddr;
         prev_data  = bus.OutData;
         if (bus.OutValid && bus.OutReady) begin
            got_oa.push_back(bus.MemAddr);
            got_od.push_back(bus.OutData);
         end
         if (bus.Done) begin
            done_cnt++;
            check("done_drives_zero", drives(), 0);
            fin = 1'b1;
         end
         tick();
         cyc++;
      end

      bus.Ack = 1'b0;
      bus.Go = 1'b0;
      bus.InValid = 1'b0;
      bus.OutReady = 1'b0;
      #1;
      check("job_finished", 64'(fin), 1);
      check("done_once", 64'(done_cnt), 1);
      check("busy_through_job", 64'(busy_gap), 0);
      check("idle_after_done", 64'({bus.Busy, bus.Done}), 0);
      check("run_cycles", 64'(bus.RunCycles), 64'(exp_rc));
      check("timed_out", 64'(bus.TimedOut), 64'(exp_to));
      check("run_len_seen", 64'(run_seen), 64'(exp_rc));
      check("start_len", 64'(start_cnt), 64'(SC));
      if (ni > 0) check("start_after_load", 64'(first_start), 64'(last_wr + 1));
      if (use_pat && ni > 0) check("last_write_cycle", 64'(last_wr), 64'(exp_last));
      if (exp_to) check("no_outvalid_on_timeout", 64'(ov_cnt), 0);
      check("n_writes", 64'(got_wa.size()), 64'(exp_wa.size()));
      for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
         check("wr_addr", 64'(got_wa[i]), 64'(exp_wa[i]));
         check("wr_data", 64'(got_wd[i]), 64'(exp_wd[i]));
      end
      check("n_out", 64'(got_oa.size()), 64'(exp_oa.size()));
      for (int i = 0; i < exp_oa.size() && i < got_oa.size(); i++) begin
         check("out_addr", 64'(got_oa[i]), 64'(exp_oa[i]));
         check("out_data", 64'(got_od[i]), 64'(exp_od[i]));
      end
      tick();
      tick();
      check("result_hold", 64'({bus.TimedOut, bus.RunCycles}), 64'({exp_to, 16'(exp_rc)}));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int ndone;
      bus.Go = 1'b0;
      bus.InValid = 1'b0;
      bus.InData = '0;
      bus.OutReady = 1'b0;
      bus.Ack = 1'b0;
      bus.NumIn = '0;
      bus.NumOut = '0;
      bus.BaseIn = '0;
      bus.BaseOut = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      Reset = 1'b0;
      tick();
      tick();
      check("reset_outputs", all_out(), 0);
      Reset = 1'b1;
      tick();
      check("idle_outputs", all_out(), 0);

      // Contiguous load of three bytes, no drain
      pre_din = '{8'hA1, 8'hB2, 8'hC3};
      run_job(3, 0, 8'h10, 8'h00, 2, 8'hFF, 8'hFF, 1'b1, 1'b0);
      check("mem_10", 64'(mem[8'h10]), 64'h A1);
      check("mem_11", 64'(mem[8'h11]), 64'h B2);
      check("mem_12", 64'(mem[8'h12]), 64'h C3);

      // Load with valid gaps 1,0,0,1
      run_job(2, 0, 8'h40, 8'h00, 3, 8'b0000_1001, 8'hFF, 1'b1, 1'b0);

      // Drain across the top of memory with a 3-cycle stall on the first beat
      mem[8'hFE] = 8'h5A;
      mem[8'hFF] = 8'h3C;
      run_job(0, 2, 8'h00, 8'hFE, 5, 8'hFF, 8'b1111_1000, 1'b1, 1'b0);

      // Timeout, then a job that must clear TimedOut
      run_job(1, 3, 8'h80, 8'h80, 100, 8'hFF, 8'hFF, 1'b1, 1'b0);
      // Ack on the final permitted cycle beats the timeout; load wraps
      run_job(2, 2, 8'hFF, 8'hFF, int'(TO), 8'hFF, 8'hFF, 1'b1, 1'b0);

      // Empty job
      run_job(0, 0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 1'b1, 1'b0);

      // Go pulsed throughout RUN is ignored
      run_job(3, 2, 8'h20, 8'h21, 4, 8'h00, 8'h00, 1'b0, 1'b1);

      // Random jobs, plus one maximum-length job
      for (int j = 0; j < 30; j++) begin
         run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                 8'($urandom), 8'($urandom), int'($urandom_range(1, 10)),
                 8'h00, 8'h00, 1'b0, 1'($urandom));
      end
      run_job(255, 255, 8'($urandom), 8'($urandom), 3, 8'h00, 8'h00, 1'b0, 1'b0);

      // Reset during DRAIN abandons the job without a Done pulse
      bus.Go = 1'b1;
      bus.NumIn = 8'd0;
      bus.NumOut = 8'd4;
      bus.BaseIn = 8'h00;
      bus.BaseOut = 8'h30;
      tick();
      bus.Go = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         bus.Ack = bus.Busy && !bus.MemSel && !bus.Start && !bus.Done;
         bus.OutReady = 1'b0;
         if (bus.OutValid) seen = 1'b1;
         else tick();
      end
      check("reached_drain", 64'(seen), 1);
      bus.Ack = 1'b0;
      bus.OutReady = 1'b1;
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      check("reset_mid_drain", all_out(), 0);
      ndone = 0;
      for (int c = 0; c < 4; c++) begin
         if (bus.Done || bus.Busy) ndone++;
         tick();
      end
      check("no_done_after_reset", 64'(ndone), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
